// File: rtl/demux_lane_scheduler.sv
// demux_lane_scheduler: stripes a byte stream alternately across two demux lanes.
// A paused target lane stalls the whole stream, so byte order is preserved.
// An enable/flush FSM makes sure the stream only stops on a lane-pair boundary.
// Completed lane pairs are counted for link monitoring.
module demux_lane_scheduler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             validIn,
    input  logic [WIDTH-1:0] In0,
    input  logic             pause0,
    input  logic             pause1,
    output logic             ready,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             outValid0,
    output logic             outValid1,
    output logic             sel,
    output logic             active,
    output logic [7:0]       pair_count
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFlush
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   accept;
    logic   sel_d;
    logic   sel_paused;

    // Handshake: only the selected lane's pause can hold the stream.
    always_comb begin
        sel_paused = sel ? pause1 : pause0;
        ready      = (state_q != StIdle) && !sel_paused;
        accept     = validIn && ready;
        sel_d      = sel ^ accept;
    end

    // Next state is decided on the post-accept lane select, so dropping enable
    // on the cycle that completes a pair goes straight to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!enable) begin
                    state_d = sel_d ? StFlush : StIdle;
                end
            end
            StFlush: begin
                if (enable) begin
                    state_d = StActive;
                end else if (!sel_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and all registered outputs; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel        <= 1'b0;
            active     <= 1'b0;
            pair_count <= 8'd0;
            outValid0  <= 1'b0;
            outValid1  <= 1'b0;
            data_out0  <= '0;
            data_out1  <= '0;
        end else begin
            state_q   <= state_d;
            active    <= (state_d != StIdle);
            sel       <= sel_d;
            outValid0 <= accept && !sel;
            outValid1 <= accept && sel;
            if (accept && !sel) begin
                data_out0 <= In0;
            end
            if (accept && sel) begin
                data_out1  <= In0;
                // Lane 1 byte closes the pair; counter wraps silently.
                pair_count <= pair_count + 8'd1;
            end
        end
    end

endmodule
